// File: rtl/sram_arb_pkg.sv
// Shared types for the two-host SRAM port-A arbiter: TL-UL link structs, host ID and arbiter states.
package sram_arb_pkg;

    localparam int NumHosts = 2;

    typedef logic [0:0] host_id_t;

    typedef enum logic {ArbIdle, ArbLock} arb_state_e;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/sram_arb_id_fifo.sv
// In-order FIFO of host IDs for requests the device has accepted but not yet answered.
module sram_arb_id_fifo
    import sram_arb_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  host_id_t push_id_i,
    input  logic     pop_i,
    output host_id_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    host_id_t        mem_q [Depth];
    host_id_t        mem_d [Depth];
    logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_i) begin
            mem_d[wr_q] = push_id_i;
            wr_d = (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + PtrW'(1);
        end
        if (pop_i) begin
            rd_d = (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + PtrW'(1);
        end
        unique case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/sram_host_arb.sv
// Round-robin arbiter sharing one TL-UL link to SRAM port A between two hosts, with in-order
// response routing. Define SRAM_HOST_ARB_PERF_EN to add grant/stall counters on perf_cnt_o.
module sram_host_arb
    import sram_arb_pkg::*;
#(
    parameter int MaxOutstanding = 2
`ifdef SRAM_HOST_ARB_PERF_EN
    ,
    parameter int PerfCntWidth = 16
`endif
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  tl_h2d_t tl_h0_i,
    output tl_d2h_t tl_h0_o,
    input  tl_h2d_t tl_h1_i,
    output tl_d2h_t tl_h1_o,
    output tl_h2d_t tl_dev_o,
    input  tl_d2h_t tl_dev_i,
    output logic    rsp_err_o
`ifdef SRAM_HOST_ARB_PERF_EN
    ,
    output logic [3*PerfCntWidth-1:0] perf_cnt_o
`endif
);

    arb_state_e          state_q, state_d;
    host_id_t            rr_q, rr_d, gnt_q, gnt_d;
    host_id_t            sel, head_id;
    logic                err_q, err_d;
    logic [NumHosts-1:0] host_vld;
    logic                sel_vld, dev_a_rdy, a_hs, d_rdy, d_hs;
    logic                fifo_full, fifo_empty;

    always_comb begin : arb
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_d     = rr_q;
        host_vld = {tl_h1_i.a_valid, tl_h0_i.a_valid} & {NumHosts{~rst_i}};
        if (state_q == ArbLock)  sel = gnt_q;
        else if (&host_vld)      sel = rr_q;
        else                     sel = host_id_t'(host_vld[1]);
        sel_vld   = host_vld[sel];
        // Full FIFO is a registered condition, so d_ready never reaches a_ready combinationally.
        dev_a_rdy = tl_dev_i.a_ready & ~fifo_full & ~rst_i;
        a_hs      = sel_vld & dev_a_rdy;
        unique case (state_q)
            ArbIdle: if (sel_vld && !a_hs) begin
                state_d = ArbLock;
                gnt_d   = sel;
            end
            ArbLock: if (a_hs) state_d = ArbIdle;
            default: state_d = ArbIdle;
        endcase
        if (a_hs) rr_d = ~sel;
    end

    always_comb begin : rsp_mux
        tl_h0_o = tl_dev_i;
        tl_h1_o = tl_dev_i;
        tl_h0_o.a_ready = dev_a_rdy & (sel == 1'b0);
        tl_h1_o.a_ready = dev_a_rdy & (sel == 1'b1);
        tl_h0_o.d_valid = tl_dev_i.d_valid & ~fifo_empty & (head_id == 1'b0);
        tl_h1_o.d_valid = tl_dev_i.d_valid & ~fifo_empty & (head_id == 1'b1);
        // With nothing outstanding, stray beats are swallowed and flagged.
        if (fifo_empty) d_rdy = ~rst_i;
        else            d_rdy = head_id[0] ? tl_h1_i.d_ready : tl_h0_i.d_ready;
        d_hs  = tl_dev_i.d_valid & d_rdy & ~fifo_empty;
        err_d = err_q | (tl_dev_i.d_valid & fifo_empty);
    end

    always_comb begin : req_mux
        tl_dev_o = sel[0] ? tl_h1_i : tl_h0_i;
        tl_dev_o.a_valid = sel_vld & ~fifo_full;
        tl_dev_o.d_ready = d_rdy;
    end

    sram_arb_id_fifo #(
        .Depth(MaxOutstanding)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (a_hs),
        .push_id_i(sel),
        .pop_i    (d_hs),
        .head_o   (head_id),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ArbIdle;
            rr_q    <= '0;
            gnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
        end
    end

    assign rsp_err_o = err_q;

`ifdef SRAM_HOST_ARB_PERF_EN
    logic [PerfCntWidth-1:0] h0_cnt_q, h0_cnt_d, h1_cnt_q, h1_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin : perf
        h0_cnt_d    = h0_cnt_q;
        h1_cnt_d    = h1_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (a_hs && sel == 1'b0 && h0_cnt_q != '1) h0_cnt_d = h0_cnt_q + PerfCntWidth'(1);
        if (a_hs && sel == 1'b1 && h1_cnt_q != '1) h1_cnt_d = h1_cnt_q + PerfCntWidth'(1);
        if ((|host_vld) && !a_hs && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + PerfCntWidth'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h0_cnt_q    <= '0;
            h1_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            h0_cnt_q    <= h0_cnt_d;
            h1_cnt_q    <= h1_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_cnt_o = {stall_cnt_q, h1_cnt_q, h0_cnt_q};
`endif

endmodule

// File: tb/tb_sram_host_arb.sv
// Directed bench for sram_host_arb: bench-side SRAM device model plus per-host response scoreboard.
module tb_sram_host_arb;
    import sram_arb_pkg::*;

    localparam logic [2:0] OpPutFull = 3'h0, OpGet = 3'h4;
    localparam logic [2:0] OpAck = 3'h0, OpAckData = 3'h1;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    tl_h2d_t h0_i, h1_i, dev_o;
    tl_d2h_t h0_o, h1_o, dev_i;
    logic    rsp_err;
`ifdef SRAM_HOST_ARB_PERF_EN
    logic [47:0] perf;
`endif

    always #5 clk = ~clk;

    sram_host_arb #(.MaxOutstanding(2)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .tl_h0_i  (h0_i),
        .tl_h0_o  (h0_o),
        .tl_h1_i  (h1_i),
        .tl_h1_o  (h1_o),
        .tl_dev_o (dev_o),
        .tl_dev_i (dev_i),
        .rsp_err_o(rsp_err)
`ifdef SRAM_HOST_ARB_PERF_EN
        ,
        .perf_cnt_o(perf)
`endif
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // Device model: accepts when dev_a_rdy, answers one cycle later, queues while d_ready is low.
    logic        dev_a_rdy = 1'b1;
    logic        inj = 1'b0;
    logic [31:0] dmem [256];
    logic [2:0]  r_op [8];
    logic [7:0]  r_src [8];
    logic [31:0] r_data [8];
    logic [15:0] r_user [8];
    logic [2:0]  rwp, rrp;
    logic [3:0]  rcnt;
    logic        dev_push, dev_pop;

    assign dev_push = dev_o.a_valid && dev_i.a_ready;
    assign dev_pop  = dev_i.d_valid && dev_o.d_ready && (rcnt != 0) && !inj;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rwp  <= '0;
            rrp  <= '0;
            rcnt <= '0;
            for (int i = 0; i < 256; i++) dmem[i] <= init_val(i);
        end else begin
            if (dev_push) begin
                r_src[rwp]  <= dev_o.a_source;
                r_user[rwp] <= dev_o.a_user;
                if (dev_o.a_opcode == OpGet) begin
                    r_op[rwp]   <= OpAckData;
                    r_data[rwp] <= dmem[dev_o.a_address[9:2]];
                end else begin
                    r_op[rwp]   <= OpAck;
                    r_data[rwp] <= '0;
                    dmem[dev_o.a_address[9:2]] <= dev_o.a_data;
                end
                rwp <= rwp + 3'd1;
            end
            if (dev_pop) rrp <= rrp + 3'd1;
            rcnt <= rcnt + {3'b0, dev_push} - {3'b0, dev_pop};
        end
    end

    always_comb begin
        dev_i = '0;
        dev_i.a_ready = dev_a_rdy;
        if (rcnt != 0) begin
            dev_i.d_valid  = 1'b1;
            dev_i.d_opcode = r_op[rrp];
            dev_i.d_source = r_src[rrp];
            dev_i.d_data   = r_data[rrp];
            dev_i.d_user   = r_user[rrp];
        end
        if (inj) begin
            dev_i.d_valid  = 1'b1;
            dev_i.d_source = 8'hEE;
            dev_i.d_data   = 32'hBAD0_BAD0;
        end
    end

    // Scoreboard: expectations pushed at host acceptance, popped at host D handshake.
    typedef struct packed {
        logic [2:0]  op;
        logic [7:0]  src;
        logic [31:0] data;
        logic [15:0] user;
    } exp_t;

    exp_t        q0[$], q1[$];
    int          gnt_log[$], rsp_log[$];
    logic [31:0] refmem [256];
    int          last_acc_rsp_cnt = 0;
    logic [31:0] last_h1_data = '0;
    logic [7:0]  last_h1_src = '0;

    task automatic record(input int h, input tl_h2d_t a);
        exp_t e;
        int   idx;
        idx = int'(a.a_address[9:2]);
        gnt_log.push_back(h);
        last_acc_rsp_cnt = rsp_log.size();
        e.src  = a.a_source;
        e.user = a.a_user;
        if (a.a_opcode == OpGet) begin
            e.op   = OpAckData;
            e.data = refmem[idx];
        end else begin
            e.op   = OpAck;
            e.data = '0;
            refmem[idx] = a.a_data;
        end
        if (h == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic take(input int h, input tl_d2h_t d);
        exp_t e;
        logic have;
        rsp_log.push_back(h);
        if (h == 1) begin
            last_h1_data = d.d_data;
            last_h1_src  = d.d_source;
        end
        have = (h == 0) ? (q0.size() != 0) : (q1.size() != 0);
        chk($sformatf("h%0d_rsp_expected", h), have, 1'b1);
        if (have) begin
            if (h == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("h%0d_rsp_opcode", h), d.d_opcode, e.op);
            chk($sformatf("h%0d_rsp_source", h), d.d_source, e.src);
            chk($sformatf("h%0d_rsp_data", h), d.d_data, e.data);
            chk($sformatf("h%0d_rsp_user", h), d.d_user, e.user);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) refmem[i] = init_val(i);
        end else begin
            if (h0_i.a_valid && h0_o.a_ready) record(0, h0_i);
            if (h1_i.a_valid && h1_o.a_ready) record(1, h1_i);
            if (h0_o.d_valid && h0_i.d_ready) take(0, h0_o);
            if (h1_o.d_valid && h1_i.d_ready) take(1, h1_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int h, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [7:0] src);
        tl_h2d_t a;
        a = (h == 0) ? h0_i : h1_i;
        a.a_valid   = 1'b1;
        a.a_opcode  = op;
        a.a_size    = 2'd2;
        a.a_mask    = 4'hF;
        a.a_address = addr;
        a.a_data    = data;
        a.a_source  = src;
        a.a_user    = {8'h5A, src};
        if (h == 0) h0_i = a;
        else        h1_i = a;
    endtask

    task automatic clr(input int h);
        if (h == 0) h0_i.a_valid = 1'b0;
        else        h1_i.a_valid = 1'b0;
    endtask

    task automatic wait_acc(input int h, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = (h == 0) ? (h0_i.a_valid && h0_o.a_ready) : (h1_i.a_valid && h1_o.a_ready);
        end
        chk({tag, "_accept"}, ok, 1'b1);
        if (ok) tick();
        clr(h);
    endtask

    task automatic issue(input int h, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [7:0] src, input string tag);
        drive(h, op, addr, data, src);
        wait_acc(h, tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && (q0.size() + q1.size()) != 0; i++) tick();
        tick();
        chk({tag, "_drain"}, 64'(q0.size() + q1.size()), 64'd0);
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        rsp_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

`ifdef SRAM_HOST_ARB_PERF_EN
    logic [47:0] snap;
`endif

    initial begin
        h0_i = '0;
        h1_i = '0;
        h0_i.d_ready = 1'b1;
        h1_i.d_ready = 1'b1;
        h0_i.a_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_h0_a_ready", h0_o.a_ready, 1'b0);
        chk("rst_h1_a_ready", h1_o.a_ready, 1'b0);
        chk("rst_dev_a_valid", dev_o.a_valid, 1'b0);
        chk("rst_h0_d_valid", h0_o.d_valid, 1'b0);
        chk("rst_h1_d_valid", h1_o.d_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        h0_i.a_valid = 1'b0;
        tick();

        // 1: write by h0, read back by h1
        issue(0, OpPutFull, 32'h1000, 32'hDEAD_BEEF, 8'h11, "t1_wr");
        issue(1, OpGet, 32'h1000, 32'h0, 8'h22, "t1_rd");
        drain("t1");
        chk("t1_rsp_count", 64'(rsp_log.size()), 64'd2);
        chk("t1_first_rsp_host", 64'(rsp_log[0]), 64'd0);
        chk("t1_h1_data", last_h1_data, 32'hDEAD_BEEF);
        chk("t1_h1_source", last_h1_src, 8'h22);
        clear_logs();

        // 2: both hosts contend for 4 cycles
`ifdef SRAM_HOST_ARB_PERF_EN
        snap = perf;
`endif
        drive(0, OpGet, 32'h1004, 32'h0, 8'h31);
        drive(1, OpGet, 32'h1008, 32'h0, 8'h41);
        repeat (4) tick();
        clr(0);
        clr(1);
        drain("t2");
        chk("t2_gnt_count", 64'(gnt_log.size()), 64'd4);
        if (gnt_log.size() == 4)
            for (int i = 0; i < 4; i++) chk($sformatf("t2_gnt%0d", i), 64'(gnt_log[i]), 64'(i % 2));
`ifdef SRAM_HOST_ARB_PERF_EN
        chk("t2_perf_h0", perf[15:0] - snap[15:0], 16'd2);
        chk("t2_perf_h1", perf[31:16] - snap[31:16], 16'd2);
`endif
        clear_logs();

        // 3: device stalls for 3 cycles with h1 locked in
`ifdef SRAM_HOST_ARB_PERF_EN
        snap = perf;
`endif
        dev_a_rdy = 1'b0;
        drive(1, OpGet, 32'h100C, 32'h0, 8'h52);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("t3_src_c%0d", c), dev_o.a_source, 8'h52);
            chk($sformatf("t3_addr_c%0d", c), dev_o.a_address, 32'h100C);
            chk($sformatf("t3_h0_blocked_c%0d", c), h0_o.a_ready, 1'b0);
            tick();
            if (c == 0) drive(0, OpGet, 32'h1010, 32'h0, 8'h61);
        end
        dev_a_rdy = 1'b1;
        wait_acc(1, "t3_h1");
        wait_acc(0, "t3_h0");
        drain("t3");
        chk("t3_gnt_count", 64'(gnt_log.size()), 64'd2);
        if (gnt_log.size() == 2) begin
            chk("t3_gnt0", 64'(gnt_log[0]), 64'd1);
            chk("t3_gnt1", 64'(gnt_log[1]), 64'd0);
        end
`ifdef SRAM_HOST_ARB_PERF_EN
        chk("t3_perf_stall", perf[47:32] - snap[47:32], 16'd3);
`endif
        clear_logs();

        // 4: FIFO full with h0 responses blocked
        h0_i.d_ready = 1'b0;
        issue(0, OpGet, 32'h1014, 32'h0, 8'h71, "t4_r0");
        issue(0, OpGet, 32'h1018, 32'h0, 8'h72, "t4_r1");
        drive(1, OpGet, 32'h101C, 32'h0, 8'h81);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("t4_h1_a_ready_c%0d", c), h1_o.a_ready, 1'b0);
            chk($sformatf("t4_dev_a_valid_c%0d", c), dev_o.a_valid, 1'b0);
            tick();
        end
        h0_i.d_ready = 1'b1;
        wait_acc(1, "t4_r2");
        chk("t4_h1_after_first_d", 64'(last_acc_rsp_cnt), 64'd1);
        drain("t4");
        chk("t4_rsp_count", 64'(rsp_log.size()), 64'd3);
        if (rsp_log.size() == 3) begin
            chk("t4_rsp0", 64'(rsp_log[0]), 64'd0);
            chk("t4_rsp1", 64'(rsp_log[1]), 64'd0);
            chk("t4_rsp2", 64'(rsp_log[2]), 64'd1);
        end
        clear_logs();

        // 5: stray response with nothing outstanding
        @(negedge clk);
        chk("t5_err_before", rsp_err, 1'b0);
        tick();
        inj = 1'b1;
        @(negedge clk);
        chk("t5_h0_d_valid", h0_o.d_valid, 1'b0);
        chk("t5_h1_d_valid", h1_o.d_valid, 1'b0);
        chk("t5_dev_d_ready", dev_o.d_ready, 1'b1);
        tick();
        inj = 1'b0;
        @(negedge clk);
        chk("t5_err_set", rsp_err, 1'b1);
        repeat (5) tick();
        chk("t5_err_sticky", rsp_err, 1'b1);

        // 6: reset with two requests outstanding
        h0_i.d_ready = 1'b0;
        issue(0, OpGet, 32'h1020, 32'h0, 8'h91, "t6_r0");
        issue(0, OpGet, 32'h1024, 32'h0, 8'h92, "t6_r1");
        drive(1, OpGet, 32'h1028, 32'h0, 8'hA1);
        drive(0, OpGet, 32'h102C, 32'h0, 8'h93);
        rst = 1'b1;
        #1;
        chk("t6_h0_a_ready", h0_o.a_ready, 1'b0);
        chk("t6_h1_a_ready", h1_o.a_ready, 1'b0);
        chk("t6_dev_a_valid", dev_o.a_valid, 1'b0);
        chk("t6_h0_d_valid", h0_o.d_valid, 1'b0);
        chk("t6_h1_d_valid", h1_o.d_valid, 1'b0);
        chk("t6_dev_d_ready", dev_o.d_ready, 1'b0);
        chk("t6_rsp_err", rsp_err, 1'b0);
        q0.delete();
        q1.delete();
        clear_logs();
        h0_i.d_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_acc(0, "t6_h0");
        wait_acc(1, "t6_h1");
        drain("t6");
        chk("t6_gnt_count", 64'(gnt_log.size()), 64'd2);
        if (gnt_log.size() == 2) chk("t6_first_gnt", 64'(gnt_log[0]), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
